cmd_stream_bridge: RTL and testbench



---
 rtl/cmd_stream_bridge.sv | 159 +++++++++++++++
 tb/tb_cmd_stream_bridge.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_stream_bridge.sv
// cmd_stream_bridge: framed byte stream (SYNC ADDR D3 D2 D1 D0 CSUM) to
// single-cycle register writes on the cmd_addr/cmd_data/cmd_wr bus.
// Frames with a bad checksum or an inter-byte timeout are dropped and reported.
// Optional build macro CMD_ACK_EN adds an ack byte (06 good / 15 error) with a
// valid/ready handshake; when undefined the ack outputs are tied to zero.
//
// state  | meaning
// IDLE   | waiting for SYNC_BYTE, other bytes ignored
// ADDR   | expecting register address byte
// D3..D0 | expecting data bytes, MSB first
// CSUM   | expecting checksum byte, frame completes on it
module cmd_stream_bridge #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic [7:0]  o_cmd_addr,
   output logic [31:0] o_cmd_data,
   output logic        o_cmd_wr,
   output logic        o_busy,
   output logic        o_frame_err,
   output logic [1:0]  o_err_code,
   output logic [15:0] o_frame_cnt,
   output logic [7:0]  o_ack_data,
   output logic        o_ack_valid,
   input  logic        i_ack_ready
);

   localparam int            CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_D3, S_D2, S_D1, S_D0, S_CSUM
   } state_t;

   state_t        state, state_next;
   logic [7:0]    sum;
   logic [7:0]    frame_sum;
   logic [7:0]    sh_addr;
   logic [31:0]   sh_data;
   logic [CW-1:0] tmr;
   logic          good, bad, tmo;

   assign frame_sum = sum + i_rx_data;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state and frame completion decode; a byte in the terminal-count
   // cycle wins over the timeout
   always_comb begin
      state_next = state;
      good       = 1'b0;
      bad        = 1'b0;
      tmo        = 1'b0;
      case (state)
         S_IDLE: if (i_rx_valid && i_rx_data == SYNC_BYTE) state_next = S_ADDR;
         S_ADDR: if (i_rx_valid) state_next = S_D3;
         S_D3:   if (i_rx_valid) state_next = S_D2;
         S_D2:   if (i_rx_valid) state_next = S_D1;
         S_D1:   if (i_rx_valid) state_next = S_D0;
         S_D0:   if (i_rx_valid) state_next = S_CSUM;
         S_CSUM: if (i_rx_valid) begin
            state_next = S_IDLE;
            if (frame_sum == 8'h00) good = 1'b1;
            else                    bad  = 1'b1;
         end
         default: state_next = S_IDLE;
      endcase
      if (state != S_IDLE && !i_rx_valid && tmr == TC) begin
         state_next = S_IDLE;
         tmo        = 1'b1;
      end
   end

   // Busy whenever a frame is partially received
   always_comb begin
      o_busy = (state != S_IDLE);
   end

   // Shadow capture of address/data and the running checksum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum     <= 8'h00;
         sh_addr <= 8'h00;
         sh_data <= 32'h0;
      end else if (i_rx_valid) begin
         case (state)
            S_IDLE: if (i_rx_data == SYNC_BYTE) sum <= 8'h00;
            S_ADDR: begin sh_addr <= i_rx_data;        sum <= frame_sum; end
            S_D3:   begin sh_data[31:24] <= i_rx_data; sum <= frame_sum; end
            S_D2:   begin sh_data[23:16] <= i_rx_data; sum <= frame_sum; end
            S_D1:   begin sh_data[15:8]  <= i_rx_data; sum <= frame_sum; end
            S_D0:   begin sh_data[7:0]   <= i_rx_data; sum <= frame_sum; end
            default: ;
         endcase
      end
   end

   // Inter-byte timer: idle or any byte restarts it, otherwise it counts up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    tmr <= '0;
      else if (state == S_IDLE || i_rx_valid || tmo) tmr <= '0;
      else                                           tmr <= tmr + CW'(1);
   end

   // Command bus, error reporting and good-frame counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_cmd_addr  <= 8'h00;
         o_cmd_data  <= 32'h0;
         o_cmd_wr    <= 1'b0;
         o_frame_err <= 1'b0;
         o_err_code  <= 2'b00;
         o_frame_cnt <= 16'h0;
      end else begin
         o_cmd_wr    <= good;
         o_frame_err <= bad | tmo;
         if (good) begin
            o_cmd_addr  <= sh_addr;
            o_cmd_data  <= sh_data;
            o_frame_cnt <= o_frame_cnt + 16'd1;
         end
         if (bad) o_err_code <= 2'b01;
         if (tmo) o_err_code <= 2'b10;
      end
   end

`ifdef CMD_ACK_EN
   // Ack byte: latest completion status wins, cleared on handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_ack_data  <= 8'h00;
         o_ack_valid <= 1'b0;
      end else if (good) begin
         o_ack_data  <= 8'h06;
         o_ack_valid <= 1'b1;
      end else if (bad || tmo) begin
         o_ack_data  <= 8'h15;
         o_ack_valid <= 1'b1;
      end else if (o_ack_valid && i_ack_ready) begin
         o_ack_data  <= 8'h00;
         o_ack_valid <= 1'b0;
      end
   end
`else
   logic unused_ack_ready;
   assign unused_ack_ready = i_ack_ready;
   assign o_ack_data       = 8'h00;
   assign o_ack_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_stream_bridge.sv
// Bench for cmd_stream_bridge (TIMEOUT_CYCLES=16): directed frames from the
// test plan plus randomized frames, checked every cycle against a frame-level
// model. Build with +define+CMD_ACK_EN to exercise the ack feature.
module tb_cmd_stream_bridge;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         TMO  = 16;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        ack_ready;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        cmd_wr;
   logic        busy;
   logic        frame_err;
   logic [1:0]  err_code;
   logic [15:0] frame_cnt;
   logic [7:0]  ack_data;
   logic        ack_valid;

   int n_vec = 0;
   int n_err = 0;
   int n_wr  = 0;
   bit rnd_ready = 1'b0;

   always #5 clk = ~clk;

   cmd_stream_bridge #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_cmd_addr(cmd_addr), .o_cmd_data(cmd_data), .o_cmd_wr(cmd_wr),
      .o_busy(busy), .o_frame_err(frame_err), .o_err_code(err_code),
      .o_frame_cnt(frame_cnt), .o_ack_data(ack_data), .o_ack_valid(ack_valid),
      .i_ack_ready(ack_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: payload queue, idle-gap count, expected outputs
   bit          m_in;
   bq_t         m_q;
   int          m_gap;
   logic [7:0]  m_addr, m_ackd, m_sum;
   logic [31:0] m_data;
   logic        m_wr, m_err, m_ackv, m_done, m_good;
   logic [1:0]  m_code;
   logic [15:0] m_cnt;

   always @(posedge clk) begin
      m_wr = 1'b0; m_err = 1'b0; m_done = 1'b0; m_good = 1'b0;
      if (!rst_n) begin
         m_in = 1'b0; m_q.delete(); m_gap = 0;
         m_addr = 8'h00; m_data = 32'h0; m_code = 2'b00; m_cnt = 16'h0;
         m_ackd = 8'h00; m_ackv = 1'b0;
      end else begin
         if (rx_valid) begin
            if (!m_in) begin
               if (rx_data == SYNC) begin m_in = 1'b1; m_q.delete(); m_gap = 0; end
            end else if (m_q.size() < 5) begin
               m_q.push_back(rx_data);
               m_gap = 0;
            end else begin
               m_sum = rx_data;
               foreach (m_q[i]) m_sum = m_sum + m_q[i];
               m_done = 1'b1;
               m_in   = 1'b0;
               if (m_sum == 8'h00) begin
                  m_good = 1'b1; m_wr = 1'b1;
                  m_addr = m_q[0];
                  m_data = {m_q[1], m_q[2], m_q[3], m_q[4]};
                  m_cnt  = m_cnt + 16'd1;
               end else begin
                  m_err = 1'b1; m_code = 2'b01;
               end
            end
         end else if (m_in) begin
            m_gap++;
            if (m_gap >= TMO) begin
               m_err = 1'b1; m_code = 2'b10; m_in = 1'b0; m_done = 1'b1;
            end
         end
`ifdef CMD_ACK_EN
         if (m_done) begin
            m_ackv = 1'b1;
            m_ackd = m_good ? 8'h06 : 8'h15;
         end else if (m_ackv && ack_ready) begin
            m_ackv = 1'b0;
            m_ackd = 8'h00;
         end
`endif
      end
      #1;
      if (cmd_wr === 1'b1) n_wr++;
      chk("cmd_wr",    32'(cmd_wr),    32'(m_wr));
      chk("frame_err", 32'(frame_err), 32'(m_err));
      chk("busy",      32'(busy),      32'(m_in));
      chk("err_code",  32'(err_code),  32'(m_code));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      chk("cmd_addr",  32'(cmd_addr),  32'(m_addr));
      chk("cmd_data",  cmd_data,       m_data);
      chk("ack_valid", 32'(ack_valid), 32'(m_ackv));
      chk("ack_data",  32'(ack_data),  32'(m_ackd));
   end

   task automatic drive(input logic v, input logic [7:0] d);
      @(negedge clk);
      rx_valid = v;
      rx_data  = d;
      if (rnd_ready) ack_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
   endtask

   // Bytes back-to-back; returns at the negedge one clock after the last strobe
   task automatic send(input bq_t b);
      foreach (b[i]) drive(1'b1, b[i]);
      drive(1'b0, 8'h00);
   endtask

   initial begin
      bq_t f1, f2, fbad, fpair, q;
      int  w0, gap, nj;
      logic [7:0] s, j;
      f1    = '{8'hA5, 8'h28, 8'hC0, 8'hA8, 8'h01, 8'h0A, 8'h65};
      f2    = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFD};
      fbad  = '{8'hA5, 8'h28, 8'hC0, 8'hA8, 8'h01, 8'h0A, 8'h66};
      fpair = '{8'hA5, 8'h28, 8'hC0, 8'hA8, 8'h01, 8'h0A, 8'h65,
                8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFD};

      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; ack_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst cmd_data", cmd_data, 32'd0);

      // Good frame
      send(f1);
      chk("f1 wr", 32'(cmd_wr), 32'd1);
      chk("f1 addr", 32'(cmd_addr), 32'h28);
      chk("f1 data", cmd_data, 32'hC0A8010A);
      chk("f1 cnt", 32'(frame_cnt), 32'd1);
      idle(3);

      // Bad checksum
      send(fbad);
      chk("bad wr", 32'(cmd_wr), 32'd0);
      chk("bad err", 32'(frame_err), 32'd1);
      chk("bad code", 32'(err_code), 32'd1);
      chk("bad data held", cmd_data, 32'hC0A8010A);
      chk("bad cnt", 32'(frame_cnt), 32'd1);
      idle(2);

      // Two frames with no gap
      w0 = n_wr;
      send(fpair);
      chk("pair addr", 32'(cmd_addr), 32'h02);
      chk("pair data", cmd_data, 32'h00000001);
      chk("pair cnt", 32'(frame_cnt), 32'd3);
      chk("pair writes", 32'(n_wr - w0), 32'd2);
      idle(2);

      // Timeout 16 cycles after the ADDR strobe
      send('{8'hA5, 8'h28});
      idle(15);
      chk("tmo early err", 32'(frame_err), 32'd0);
      chk("tmo early busy", 32'(busy), 32'd1);
      idle(1);
      chk("tmo err", 32'(frame_err), 32'd1);
      chk("tmo code", 32'(err_code), 32'd2);
      chk("tmo busy", 32'(busy), 32'd0);
      idle(2);

      // Byte arriving exactly on the terminal count wins
      send('{8'hA5, 8'h28});
      idle(14);
      send('{8'hC0, 8'hA8, 8'h01, 8'h0A, 8'h65});
      chk("edge wr", 32'(cmd_wr), 32'd1);
      chk("edge cnt", 32'(frame_cnt), 32'd4);
      idle(2);

      // Junk ignored, then a good frame
      send('{8'h00, 8'hFF, 8'h3C});
      chk("junk err", 32'(frame_err), 32'd0);
      chk("junk busy", 32'(busy), 32'd0);
      send(f1);
      chk("junk f1 wr", 32'(cmd_wr), 32'd1);
      chk("junk f1 cnt", 32'(frame_cnt), 32'd5);
      idle(2);

      // Reset mid-frame
      send('{8'hA5, 8'h28, 8'hC0});
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      chk("rstmid busy", 32'(busy), 32'd0);
      idle(3);
      chk("rstmid err", 32'(frame_err), 32'd0);
      chk("rstmid wr", 32'(cmd_wr), 32'd0);
      chk("rstmid cnt", 32'(frame_cnt), 32'd0);

      // Ack: good then bad with consumer stalled, then one ready cycle
      ack_ready = 1'b0;
      send(f1);
      send(fbad);
      idle(2);
`ifdef CMD_ACK_EN
      chk("ack pending", 32'(ack_valid), 32'd1);
      chk("ack latest", 32'(ack_data), 32'h15);
`else
      chk("ack off valid", 32'(ack_valid), 32'd0);
      chk("ack off data", 32'(ack_data), 32'h00);
`endif
      @(negedge clk); ack_ready = 1'b1;
      @(negedge clk); ack_ready = 1'b0;
      chk("ack cleared", 32'(ack_valid), 32'd0);

      // Randomized frames: junk, random gaps around the timeout, bad checksums
      rnd_ready = 1'b1;
      for (int f = 0; f < 150; f++) begin
         q.delete();
         nj = $urandom_range(0, 2);
         for (int k = 0; k < nj; k++) begin
            j = 8'($urandom_range(0, 255));
            if (j == SYNC) j = 8'h00;
            q.push_back(j);
         end
         q.push_back(SYNC);
         s = 8'h00;
         for (int k = 0; k < 5; k++) begin
            j = 8'($urandom_range(0, 255));
            q.push_back(j);
            s = s + j;
         end
         j = 8'h00 - s;
         if ($urandom_range(0, 3) == 0) j = j ^ 8'($urandom_range(1, 255));
         q.push_back(j);
         foreach (q[k]) begin
            gap = ($urandom_range(0, 19) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 1);
            idle(gap);
            drive(1'b1, q[k]);
         end
         drive(1'b0, 8'h00);
      end
      rnd_ready = 1'b0;
      idle(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
